// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-beat stream plus instruction-memory write port
//   in_valid/in_ready handshake with symbolic fields in_cls, in_rd, in_rs1, in_rs2,
//   in_funct3, in_alt, in_imm; registered write port imem_we, imem_addr, imem_wdata.
//   master = beat source / memory side, slave = encoder.
interface instr_encoder_loader_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_cls;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [12:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (
        output in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic RV32I fields (R/LOAD/STORE/BRANCH) and writes them to imem
//   clk, rst_n      clock, asynchronous active-low reset
//   start, finish   pulses: restart program load / end program
//   bus             field stream in, registered imem write port out
//   count           words written since start
//   done            high while in DONE
//   err             sticky: BRANCH beat with odd immediate
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 finish,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]      count,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d, err_q, err_d, acc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, enc;
    assign bus.in_ready   = state_q == LOAD && count_q < DEPTH_C;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count = count_q;
    assign done  = state_q == DONE;
    assign err   = err_q;
    always_comb begin
        // start on the accept edge drops the beat
        acc = bus.in_valid && bus.in_ready && !start;
        enc = bus.in_cls == 2'b00 ? {bus.in_alt ? 7'b0100000 : 7'b0, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011} :
              bus.in_cls == 2'b01 ? {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011} :
              bus.in_cls == 2'b10 ? {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0], 7'b0100011} :
                                    {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        we_d    = acc;
        addr_d  = acc ? count_q[ADDR_W-1:0] : addr_q;
        wdata_d = acc ? enc : wdata_q;
        count_d = start ? '0 : count_q + (ADDR_W+1)'(acc);
        err_d   = !start && (err_q || (acc && bus.in_cls == 2'b11 && bus.in_imm[0]));
        state_d = start ? LOAD : (state_q == LOAD && (finish || count_d == DEPTH_C)) ? DONE : state_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven vectors plus corner-case sequences, DEPTH=4
module tb_instr_encoder_loader;
    logic       clk = 0, rst_n = 0, start = 0, finish = 0;
    logic [8:0] count;
    logic       done, err;
    int         n_pass = 0, n_tot = 0;
    instr_encoder_loader_if #(.ADDR_W(8)) bus ();
    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .bus(bus.slave), .count(count), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [12:0] imm;
        logic [31:0] wdata;
    } vec_t;
    vec_t v[8];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic drive(input vec_t x);
        bus.in_cls = x.cls; bus.in_rd = x.rd; bus.in_rs1 = x.rs1; bus.in_rs2 = x.rs2;
        bus.in_funct3 = x.f3; bus.in_alt = x.alt; bus.in_imm = x.imm;
    endtask
    task automatic step;
        @(posedge clk); #1;
        start = 0; finish = 0; bus.in_valid = 0;
    endtask
    task automatic do_start;
        @(negedge clk); start = 1; step();
        chk("start_ready", 32'(bus.in_ready), 1);
        chk("start_count", 32'(count), 0);
    endtask
    function automatic vec_t rbeat(input logic [4:0] rd);
        rbeat = '{2'b00, rd, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 32'h00208033 | (32'(rd) << 7)};
    endfunction
    initial begin
        logic em;
        bus.in_valid = 0;
        v[0] = '{2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0,      32'h002081B3};
        v[1] = '{2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0,      32'h402081B3};
        v[2] = '{2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'd8,      32'h00812283};
        v[3] = '{2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 13'd12,     32'h00512623};
        v[4] = '{2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd8,      32'h00208463};
        v[5] = '{2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd9,      32'h00208463};
        v[6] = '{2'b01, 5'd5, 5'd2, 5'd9, 3'd2, 1'b1, 13'h1008,   32'h00812283};
        v[7] = '{2'b10, 5'd7, 5'd2, 5'd5, 3'd2, 1'b1, 13'h1FFC,   32'hFE512E23};
        drive(v[0]);
        #12;
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_we", 32'(bus.imem_we), 0);
        chk("rst_addr", 32'(bus.imem_addr), 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); bus.in_valid = 1; step();
        chk("idle_no_accept", 32'(bus.imem_we), 0);
        em = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) begin do_start(); em = 0; end
            @(negedge clk); drive(v[i]); bus.in_valid = 1; step();
            em = em | (v[i].cls == 2'b11 && v[i].imm[0]);
            chk($sformatf("v%0d_we", i), 32'(bus.imem_we), 1);
            chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(i % 4));
            chk($sformatf("v%0d_wdata", i), bus.imem_wdata, v[i].wdata);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(i % 4 + 1));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(em));
            chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(i % 4 != 3));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(i % 4 == 3));
            step();
            chk($sformatf("v%0d_we_drop", i), 32'(bus.imem_we), 0);
            chk($sformatf("v%0d_hold", i), bus.imem_wdata, v[i].wdata);
        end
        do_start();
        chk("err_cleared", 32'(err), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(rbeat(5'(i))); bus.in_valid = 1;
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_we", i), 32'(bus.imem_we), 32'(i < 4));
            if (i < 4) begin
                chk($sformatf("b2b%0d_addr", i), 32'(bus.imem_addr), 32'(i));
                chk($sformatf("b2b%0d_wdata", i), bus.imem_wdata, rbeat(5'(i)).wdata);
            end
        end
        bus.in_valid = 0;
        chk("full_count", 32'(count), 4);
        chk("full_done", 32'(done), 1);
        chk("full_ready", 32'(bus.in_ready), 0);
        do_start();
        @(negedge clk); drive(v[2]); bus.in_valid = 1; finish = 1; step();
        chk("fin_we", 32'(bus.imem_we), 1);
        chk("fin_wdata", bus.imem_wdata, v[2].wdata);
        chk("fin_done", 32'(done), 1);
        chk("fin_count", 32'(count), 1);
        chk("fin_ready", 32'(bus.in_ready), 0);
        do_start();
        @(negedge clk); drive(v[0]); bus.in_valid = 1; step();
        chk("mid_we1", 32'(bus.imem_we), 1);
        @(negedge clk); drive(v[5]); bus.in_valid = 1; start = 1; step();
        chk("mid_drop_we", 32'(bus.imem_we), 0);
        chk("mid_drop_count", 32'(count), 0);
        chk("mid_drop_err", 32'(err), 0);
        chk("mid_drop_ready", 32'(bus.in_ready), 1);
        chk("mid_drop_wdata", bus.imem_wdata, v[0].wdata);
        @(negedge clk); start = 1; finish = 1; step();
        chk("prio_ready", 32'(bus.in_ready), 1);
        chk("prio_done", 32'(done), 0);
        @(negedge clk); drive(v[5]); bus.in_valid = 1; step();
        chk("rst_pre_we", 32'(bus.imem_we), 1);
        chk("rst_pre_err", 32'(err), 1);
        rst_n = 0; #1;
        chk("arst_we", 32'(bus.imem_we), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_wdata", bus.imem_wdata, 0);
        chk("arst_ready", 32'(bus.in_ready), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
